// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time; SB/SH handled as read-modify-write of a full word.
// Latency (2-cycle memory handshake): load/SW 4, SB/SH 7, error 1 cycle from acceptance to rsp_valid.
// Backpressure: req_ready only in S_IDLE; memory stalls bounded by WAIT_LIMIT, then abort with rsp_err.
// Ports: clk/rst (sync, active-high); req_* request in, rsp_* one-cycle response out;
//        mem_* word-aligned request to memory_system, mem_ready/mem_data_out completion back.
module load_store_unit #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [3:0]  mem_write_en,
  output logic        mem_read_en,
  input  logic [31:0] mem_data_out,
  input  logic        mem_ready
);

  // Counter holds 0..WAIT_LIMIT-1; reaching the top value without mem_ready aborts.
  localparam int unsigned WW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT);
  localparam logic [WW-1:0] WAIT_TOP = WW'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RMW_RD, S_STORE, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   res_q, res_d;
  logic          err_q, err_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_data_in_q, mem_data_in_d;
  logic [3:0]    mem_we_q, mem_we_d;
  logic          mem_re_q, mem_re_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic          req_err;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic [31:0]   merged;
  logic          timed_out;

  // Request checks on the incoming (unlatched) request.
  always_comb begin
    req_err = 1'b0;
    if (req_store) begin
      if (req_funct3[2] || req_funct3 == 3'b011) req_err = 1'b1;
    end else begin
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111) req_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) req_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
  end

  // Lane extraction and store merge both work on the word currently returned by memory.
  always_comb begin
    ld_byte = mem_data_out[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_data_out[31:16] : mem_data_out[15:0];
    case (f3_q[1:0])
      2'b00:   ld_val = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
      default: ld_val = mem_data_out;
    endcase
    merged = mem_data_out;
    if (f3_q[1:0] == 2'b00) merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  assign timed_out = (wait_q == WAIT_TOP);

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    f3_d          = f3_q;
    off_d         = off_q;
    wdata_d       = wdata_q;
    res_d         = res_q;
    err_d         = err_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_we_d      = mem_we_q;
    mem_re_d      = mem_re_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = 32'h0;
    rsp_err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          wdata_d = req_wdata;
          res_d   = 32'h0;
          err_d   = req_err;
          wait_d  = '0;
          if (req_err) begin
            state_d = S_RESP;
          end else begin
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (!req_store) begin
              mem_re_d = 1'b1;
              state_d  = S_LOAD;
            end else if (req_funct3 == 3'b010) begin
              mem_we_d      = 4'hF;
              mem_data_in_d = req_wdata;
              state_d       = S_STORE;
            end else begin
              mem_re_d = 1'b1;
              state_d  = S_RMW_RD;
            end
          end
        end
      end
      S_LOAD, S_RMW_RD, S_STORE: begin
        if (mem_ready) begin
          mem_re_d = 1'b0;
          if (state_q == S_RMW_RD) begin
            // Read done: switch straight to the full-word write of the merged data.
            mem_we_d      = 4'hF;
            mem_data_in_d = merged;
            wait_d        = '0;
            state_d       = S_STORE;
          end else begin
            if (state_q == S_LOAD) res_d = ld_val;
            mem_we_d      = 4'h0;
            mem_addr_d    = 32'h0;
            mem_data_in_d = 32'h0;
            state_d       = S_RESP;
          end
        end else if (timed_out) begin
          mem_re_d      = 1'b0;
          mem_we_d      = 4'h0;
          mem_addr_d    = 32'h0;
          mem_data_in_d = 32'h0;
          err_d         = 1'b1;
          state_d       = S_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        rsp_rdata_d = err_q ? 32'h0 : res_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      wait_q        <= '0;
      f3_q          <= 3'b000;
      off_q         <= 2'b00;
      wdata_q       <= 32'h0;
      res_q         <= 32'h0;
      err_q         <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_data_in_q <= 32'h0;
      mem_we_q      <= 4'h0;
      mem_re_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
      res_q         <= res_d;
      err_q         <= err_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_write_en = mem_we_q;
  assign mem_read_en  = mem_re_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: 2-cycle-handshake memory, byte-level reference model,
// directed cases (extraction, RMW, errors, timeout, reset mid-access) plus random traffic.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [3:0]  mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_data_out = 32'h0;
  logic        mem_ready;

  logic        mem_ready_q = 1'b0;
  logic        stall = 1'b0;
  logic        spur = 1'b0;
  int          cnt = 0;
  int          reads = 0;
  int          writes = 0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] mem [0:255];
  logic [7:0]  rb  [0:1023];

  logic [31:0] last_rd;
  int          last_lat;
  logic        last_err;

  assign mem_ready = mem_ready_q | spur;

  always #5 clk = ~clk;

  load_store_unit #(.WAIT_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_out(mem_data_out), .mem_ready(mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // memory_system: request seen at one edge, ready pulse two edges later.
  always @(posedge clk) begin
    if (rst) begin
      mem_ready_q <= 1'b0;
      cnt <= 0;
    end else begin
      mem_ready_q <= 1'b0;
      if ((mem_read_en || mem_write_en != 4'h0) && !mem_ready_q && !stall) begin
        if (cnt == 1) begin
          mem_ready_q <= 1'b1;
          cnt <= 0;
          chk("addr_align", 32'(mem_addr[1:0]), 32'h0);
          if (mem_read_en) begin
            chk("rd_no_we", 32'(mem_write_en), 32'h0);
            mem_data_out <= mem[mem_addr[9:2]];
            reads++;
          end else begin
            chk("we_full", 32'(mem_write_en), 32'hF);
            for (int i = 0; i < 4; i++)
              if (mem_write_en[i]) mem[mem_addr[9:2]][8*i +: 8] = mem_data_in[8*i +: 8];
            writes++;
          end
        end else begin
          cnt <= cnt + 1;
        end
      end else begin
        cnt <= 0;
      end
    end
  end

  // After a sampled completion the read request must be gone.
  always @(posedge clk) begin
    if (mem_ready_q && !rst) begin
      #1 chk("re_drop", 32'(mem_read_en), 32'h0);
    end
  end

  function automatic logic model_err(input logic st, input logic [2:0] f3, input logic [9:0] a);
    logic legal, mis;
    legal = st ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
               : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mis = (f3[1:0] == 2'd1 && a[0]) || (f3[1:0] == 2'd2 && a[1:0] != 2'd0);
    return !legal || mis;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [9:0] a);
    case (f3)
      3'd0:    return {{24{rb[a][7]}}, rb[a]};
      3'd4:    return {24'h0, rb[a]};
      3'd1:    return {{16{rb[a+1][7]}}, rb[a+1], rb[a]};
      3'd5:    return {16'h0, rb[a+1], rb[a]};
      3'd2:    return {rb[a+3], rb[a+2], rb[a+1], rb[a]};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    for (int i = 0; i < 4; i++) rb[4*idx + i] = v[8*i +: 8];
  endtask

  task automatic start_req(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic        e;
    logic [31:0] exp_rd;
    logic [9:0]  ab;
    int          exp_lat, r0, w0, lat, nb;
    ab = a[9:0];
    e = model_err(st, f3, ab);
    exp_rd = (e || st) ? 32'h0 : model_load(f3, ab);
    exp_lat = e ? 1 : ((st && f3 != 3'd2) ? 7 : 4);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'h1);
    r0 = reads; w0 = writes;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin lat = n; break; end
    end
    last_lat = lat; last_rd = rsp_rdata; last_err = rsp_err;
    if (lat == 0) begin
      chk("rsp_timeout", 32'h0, 32'h1);
    end else begin
      chk("latency", lat, exp_lat);
      chk("rsp_err", 32'(rsp_err), 32'(e));
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("reads", reads - r0, (!e && (!st || f3 != 3'd2)) ? 1 : 0);
      chk("writes", writes - w0, (!e && st) ? 1 : 0);
      @(posedge clk);
      #1 chk("rsp_pulse", 32'(rsp_valid), 32'h0);
    end
    if (st && !e) begin
      nb = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
      for (int i = 0; i < nb; i++) rb[ab + 10'(i)] = wd[8*i +: 8];
      chk("mem_word", mem[ab[9:2]], {rb[{ab[9:2], 2'd3}], rb[{ab[9:2], 2'd2}],
                                     rb[{ab[9:2], 2'd1}], rb[{ab[9:2], 2'd0}]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, lat, w0, r0, seen;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;

    for (int w = 0; w < 256; w++) set_word(w, $urandom);
    set_word(32'h100 >> 2, 32'h8899AABB);
    set_word(32'h200 >> 2, 32'h11223344);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_data_in", mem_data_in, 32'h0);
    chk("rst_we", 32'(mem_write_en), 32'h0);
    chk("rst_re", 32'(mem_read_en), 32'h0);
    rst = 1'b0;

    // Directed extraction and RMW cases
    txn(1'b0, 3'd0, 32'h101, 32'h0);
    chk("lb_rdata", last_rd, 32'hFFFFFFAA);
    chk("lb_lat", last_lat, 4);
    txn(1'b0, 3'd5, 32'h102, 32'h0);
    chk("lhu_rdata", last_rd, 32'h00008899);
    txn(1'b0, 3'd1, 32'h102, 32'h0);
    chk("lh_rdata", last_rd, 32'hFFFF8899);
    txn(1'b1, 3'd0, 32'h203, 32'hDEADBEEF);
    chk("sb_word", mem[32'h200 >> 2], 32'hEF223344);
    chk("sb_lat", last_lat, 7);
    txn(1'b1, 3'd2, 32'h204, 32'hCAFEF00D);
    chk("sw_lat", last_lat, 4);
    chk("sw_word", mem[32'h204 >> 2], 32'hCAFEF00D);

    // Errors: no memory traffic, 1-cycle response
    txn(1'b0, 3'd2, 32'h102, 32'h0);
    chk("lw_mis_err", 32'(last_err), 32'h1);
    chk("lw_mis_lat", last_lat, 1);
    txn(1'b0, 3'd7, 32'h100, 32'h0);
    chk("ld_f3_7_err", 32'(last_err), 32'h1);
    txn(1'b1, 3'd4, 32'h100, 32'h0);

    // Stray mem_ready while idle is ignored
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    chk("spur_rsp", 32'(rsp_valid), 32'h0);
    chk("spur_re", 32'(mem_read_en), 32'h0);
    chk("spur_ready", 32'(req_ready), 32'h1);

    // Timeout with memory never answering
    stall = 1'b1;
    r0 = reads;
    start_req(1'b0, 3'd2, 32'h40, 32'h0);
    hi = mem_read_en ? 1 : 0;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) begin lat = n; break; end
      if (mem_read_en) hi++;
    end
    chk("to_rd_cycles", hi, 8);
    chk("to_lat", lat, 9);
    chk("to_err", 32'(rsp_err), 32'h1);
    chk("to_rdata", rsp_rdata, 32'h0);
    chk("to_reads", reads - r0, 0);
    stall = 1'b0;
    @(posedge clk);

    // Reset during S_STORE (SW) and during the RMW read (SH)
    for (int k = 0; k < 2; k++) begin
      stall = 1'b1;
      w0 = writes;
      start_req(1'b1, (k == 0) ? 3'd2 : 3'd1, (k == 0) ? 32'h300 : 32'h302, $urandom);
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_we", 32'(mem_write_en), 32'h0);
      chk("rst_mid_re", 32'(mem_read_en), 32'h0);
      chk("rst_mid_ready", 32'(req_ready), 32'h1);
      @(negedge clk); rst = 1'b0; stall = 1'b0;
      seen = 0;
      for (int n = 0; n < 10; n++) begin
        @(posedge clk);
        #1 if (rsp_valid) seen++;
      end
      chk("rst_mid_no_rsp", seen, 0);
      chk("rst_mid_no_write", writes - w0, 0);
    end
    chk("rst_mid_mem", mem[32'h300 >> 2], {rb[32'h303], rb[32'h302], rb[32'h301], rb[32'h300]});

    // Random traffic against the byte-level model
    for (int t = 0; t < 80; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) begin
        if (f3[1:0] == 2'd1) a[0] = 1'b0;
        if (f3[1:0] == 2'd2) a[1:0] = 2'b00;
      end
      txn(st, f3, a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
